// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bundle: redirect/hazard controls in, PC and IF/ID register out.
// Latency: none, wires only.
// Backpressure: Stall is the only hold signal; there is no ready/valid return path.
interface instruction_fetch_stage_if;
    logic        Stall;
    logic        Flush;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic [31:0] PCAddress;
    logic [31:0] Instruction;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic        Fault;
    logic [31:0] FetchCount;

    // Fetch stage side
    modport master (
        input  Stall, Flush, BranchTaken, BranchTarget, Jump, JumpTarget, Instruction,
        output PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, Fault, FetchCount
    );

    // Hazard unit, later stages and instruction memory side
    modport slave (
        output Stall, Flush, BranchTaken, BranchTarget, Jump, JumpTarget, Instruction,
        input  PCAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, Fault, FetchCount
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: owns the PC, captures the memory word into IF/ID, halts on a bad PC.
// Latency: word at PC lands in IF/ID one edge after PCAddress = PC; first capture 2 edges after reset release.
// Backpressure: Stall holds PC, IF/ID and FetchCount unless a jump/branch redirect arrives the same cycle.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          MEM_WORDS    = 1024,
    parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
    input  logic                           Clk,
    input  logic                           Rst_n,
    instruction_fetch_stage_if.master      bus
);

    localparam logic [31:0] PC_MAX = 32'(MEM_WORDS * 4 - 4);

    typedef enum logic [1:0] {FILL, RUN, HALT} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_plus4, pc_cand;
    logic [31:0] ifid_instr, ifid_pcplus4, fetch_count;
    logic        ifid_valid, fault;
    logic        redirect, advance, bad_pc;
    logic        load_pc, capture, bubble, set_fault;

    // Candidate next PC in priority order and its legality
    always_comb begin
        pc_plus4 = pc + 32'd4;
        redirect = bus.Jump | bus.BranchTaken;
        advance  = redirect | ~bus.Stall;
        if (bus.Jump)
            pc_cand = bus.JumpTarget;
        else if (bus.BranchTaken)
            pc_cand = bus.BranchTarget;
        else
            pc_cand = pc_plus4;
        bad_pc = (pc_cand[1:0] != 2'b00) || (pc_cand > PC_MAX);
    end

    // State register
    always_ff @(posedge Clk) begin
        if (!Rst_n)
            state <= FILL;
        else
            state <= state_nxt;
    end

    // Next state: FILL lasts one cycle, HALT only exits through reset
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    state_nxt = RUN;
            RUN:     if (advance && bad_pc) state_nxt = HALT;
            HALT:    state_nxt = HALT;
            default: state_nxt = FILL;
        endcase
    end

    // Per-state datapath controls
    always_comb begin
        load_pc   = 1'b0;
        capture   = 1'b0;
        bubble    = 1'b0;
        set_fault = 1'b0;
        if (state == RUN && advance) begin
            if (bad_pc) begin
                set_fault = 1'b1;
            end else begin
                load_pc = 1'b1;
                if (redirect || bus.Flush)
                    bubble = 1'b1;
                else
                    capture = 1'b1;
            end
        end
    end

    // PC, IF/ID register, fault flag and fetch counter
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            pc           <= RESET_VECTOR;
            ifid_instr   <= NOP_WORD;
            ifid_pcplus4 <= 32'd0;
            ifid_valid   <= 1'b0;
            fault        <= 1'b0;
            fetch_count  <= 32'd0;
        end else begin
            if (load_pc)
                pc <= pc_cand;
            if (capture) begin
                ifid_instr   <= bus.Instruction;
                ifid_pcplus4 <= pc_plus4;
                ifid_valid   <= 1'b1;
                fetch_count  <= fetch_count + 32'd1;
            end else if (bubble || set_fault) begin
                ifid_instr <= NOP_WORD;
                ifid_valid <= 1'b0;
            end
            if (set_fault)
                fault <= 1'b1;
        end
    end

    assign bus.PCAddress        = pc;
    assign bus.IFID_Instruction = ifid_instr;
    assign bus.IFID_PCPlus4     = ifid_pcplus4;
    assign bus.IFID_Valid       = ifid_valid;
    assign bus.Fault            = fault;
    assign bus.FetchCount       = fetch_count;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios plus randomized control traffic.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: Stall/Flush/redirects driven directly by the bench.
module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam int          MEM_WORDS = 1024;

    logic Clk = 1'b0;
    logic Rst_n;
    instruction_fetch_stage_if ifc();

    instruction_fetch_stage #(
        .RESET_VECTOR(32'h0000_0000),
        .MEM_WORDS   (MEM_WORDS),
        .NOP_WORD    (NOP)
    ) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .bus  (ifc.master)
    );

    always #5 Clk = ~Clk;

    logic [31:0] mem [MEM_WORDS];

    // Combinational instruction memory
    always_comb begin
        if (ifc.PCAddress < 32'(MEM_WORDS * 4))
            ifc.Instruction = mem[ifc.PCAddress[11:2]];
        else
            ifc.Instruction = 32'hDEAD_BEEF;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 = filling, 1 = running, 2 = halted
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_p4, m_count;
    logic        m_valid, m_fault;

    task automatic model_update();
        logic [31:0] target;
        logic        redir;
        if (!Rst_n) begin
            m_mode = 0; m_pc = 0; m_instr = NOP; m_p4 = 0;
            m_valid = 0; m_fault = 0; m_count = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            redir = ifc.Jump || ifc.BranchTaken;
            if (redir || !ifc.Stall) begin
                if (ifc.Jump)             target = ifc.JumpTarget;
                else if (ifc.BranchTaken) target = ifc.BranchTarget;
                else                      target = m_pc + 4;
                if ((target % 4) != 0 || target > MEM_WORDS * 4 - 4) begin
                    m_fault = 1; m_instr = NOP; m_valid = 0; m_mode = 2;
                end else begin
                    if (redir || ifc.Flush) begin
                        m_instr = NOP; m_valid = 0;
                    end else begin
                        m_instr = mem[m_pc / 4];
                        m_p4    = m_pc + 4;
                        m_valid = 1;
                        m_count = m_count + 1;
                    end
                    m_pc = target;
                end
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic fl, input logic br, input logic [31:0] bt,
                         input logic jp, input logic [31:0] jt);
        ifc.Stall = st; ifc.Flush = fl; ifc.BranchTaken = br; ifc.BranchTarget = bt;
        ifc.Jump = jp; ifc.JumpTarget = jt;
    endtask

    task automatic test_reset();
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        drive(0, 0, 0, 0, 0, 0);
        Rst_n = 0;
        step();
        step();
        n_checks++; if (ifc.PCAddress !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", ifc.PCAddress); end
        n_checks++; if (ifc.IFID_Instruction !== NOP) begin n_fail++; $display("FAIL reset_instr got %h want %h", ifc.IFID_Instruction, NOP); end
        n_checks++; if (ifc.IFID_PCPlus4 !== 32'h0) begin n_fail++; $display("FAIL reset_p4 got %h want 0", ifc.IFID_PCPlus4); end
        n_checks++; if (ifc.IFID_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ifc.IFID_Valid); end
        n_checks++; if (ifc.Fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b want 0", ifc.Fault); end
        n_checks++; if (ifc.FetchCount !== 32'h0) begin n_fail++; $display("FAIL reset_count got %0d want 0", ifc.FetchCount); end
    endtask

    task automatic test_free_run_stall();
        mem[0] = 32'h2008_0000; mem[1] = 32'h2009_0006; mem[2] = 32'h200A_000A;
        Rst_n = 1;
        step();
        n_checks++; if (ifc.IFID_Valid !== 1'b0 || ifc.PCAddress !== 32'h0) begin n_fail++; $display("FAIL fill_edge valid=%b pc=%h want 0/0", ifc.IFID_Valid, ifc.PCAddress); end
        step();
        n_checks++; if (ifc.IFID_Instruction !== 32'h2008_0000 || ifc.IFID_PCPlus4 !== 32'd4 || ifc.IFID_Valid !== 1'b1) begin
            n_fail++; $display("FAIL first_fetch got %h/%h/%b want 20080000/4/1", ifc.IFID_Instruction, ifc.IFID_PCPlus4, ifc.IFID_Valid); end
        step();
        n_checks++; if (ifc.IFID_Instruction !== 32'h2009_0006 || ifc.PCAddress !== 32'd8) begin
            n_fail++; $display("FAIL second_fetch got %h pc %h want 20090006 pc 8", ifc.IFID_Instruction, ifc.PCAddress); end
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (ifc.PCAddress !== 32'd8 || ifc.IFID_Instruction !== 32'h2009_0006 || ifc.FetchCount !== 32'd2) begin
                n_fail++; $display("FAIL stall_hold[%0d] pc %h instr %h cnt %0d want 8/20090006/2", i, ifc.PCAddress, ifc.IFID_Instruction, ifc.FetchCount); end
        end
        drive(0, 0, 0, 0, 0, 0);
        step();
        n_checks++; if (ifc.IFID_Instruction !== 32'h200A_000A || ifc.IFID_PCPlus4 !== 32'd12 || ifc.FetchCount !== 32'd3) begin
            n_fail++; $display("FAIL stall_resume got %h/%h/%0d want 200a000a/c/3", ifc.IFID_Instruction, ifc.IFID_PCPlus4, ifc.FetchCount); end
    endtask

    task automatic test_branch();
        drive(0, 0, 0, 0, 0, 0);
        Rst_n = 0; step(); Rst_n = 1;
        for (int i = 0; i < 5; i++) step();
        n_checks++; if (ifc.PCAddress !== 32'h10) begin n_fail++; $display("FAIL branch_setup pc %h want 10", ifc.PCAddress); end
        drive(0, 0, 1, 32'h40, 0, 0);
        step();
        n_checks++; if (ifc.PCAddress !== 32'h40 || ifc.IFID_Valid !== 1'b0 || ifc.IFID_Instruction !== NOP) begin
            n_fail++; $display("FAIL branch_redirect pc %h valid %b instr %h want 40/0/nop", ifc.PCAddress, ifc.IFID_Valid, ifc.IFID_Instruction); end
        drive(0, 0, 0, 0, 0, 0);
        step();
        n_checks++; if (ifc.IFID_PCPlus4 !== 32'h44 || ifc.IFID_Valid !== 1'b1 || ifc.IFID_Instruction !== mem[16]) begin
            n_fail++; $display("FAIL branch_target p4 %h valid %b instr %h want 44/1/%h", ifc.IFID_PCPlus4, ifc.IFID_Valid, ifc.IFID_Instruction, mem[16]); end
    endtask

    task automatic test_priority();
        logic [31:0] cnt;
        drive(1, 0, 1, 32'h40, 1, 32'h0);
        step();
        n_checks++; if (ifc.PCAddress !== 32'h0 || ifc.IFID_Valid !== 1'b0 || ifc.IFID_Instruction !== NOP) begin
            n_fail++; $display("FAIL jump_over_branch_stall pc %h valid %b instr %h want 0/0/nop", ifc.PCAddress, ifc.IFID_Valid, ifc.IFID_Instruction); end
        drive(0, 0, 0, 0, 0, 0);
        step();
        cnt = ifc.FetchCount;
        drive(1, 1, 0, 0, 0, 0);
        step();
        n_checks++; if (ifc.PCAddress !== 32'h4 || ifc.IFID_Instruction !== mem[0] || ifc.IFID_Valid !== 1'b1 || ifc.FetchCount !== cnt) begin
            n_fail++; $display("FAIL stall_over_flush pc %h instr %h valid %b want 4/%h/1", ifc.PCAddress, ifc.IFID_Instruction, ifc.IFID_Valid, mem[0]); end
        drive(0, 1, 0, 0, 0, 0);
        step();
        n_checks++; if (ifc.PCAddress !== 32'h8 || ifc.IFID_Valid !== 1'b0 || ifc.IFID_Instruction !== NOP || ifc.FetchCount !== cnt) begin
            n_fail++; $display("FAIL flush pc %h valid %b instr %h want 8/0/nop", ifc.PCAddress, ifc.IFID_Valid, ifc.IFID_Instruction); end
    endtask

    task automatic test_fault();
        logic [31:0] cnt;
        cnt = ifc.FetchCount;
        drive(0, 0, 0, 0, 1, 32'h42);
        step();
        n_checks++; if (ifc.Fault !== 1'b1 || ifc.PCAddress !== 32'h8 || ifc.IFID_Valid !== 1'b0) begin
            n_fail++; $display("FAIL misaligned_jump fault %b pc %h valid %b want 1/8/0", ifc.Fault, ifc.PCAddress, ifc.IFID_Valid); end
        for (int i = 0; i < 5; i++) begin
            drive(1'($urandom), 1'($urandom), 1, {20'h0, 10'($urandom), 2'b00}, 1'($urandom), 32'h100);
            step();
            n_checks++; if (ifc.Fault !== 1'b1 || ifc.PCAddress !== 32'h8 || ifc.IFID_Valid !== 1'b0 || ifc.FetchCount !== cnt) begin
                n_fail++; $display("FAIL halt_hold[%0d] fault %b pc %h valid %b cnt %0d", i, ifc.Fault, ifc.PCAddress, ifc.IFID_Valid, ifc.FetchCount); end
        end
        drive(0, 0, 0, 0, 0, 0);
        Rst_n = 0; step();
        n_checks++; if (ifc.Fault !== 1'b0 || ifc.PCAddress !== 32'h0) begin
            n_fail++; $display("FAIL fault_reset fault %b pc %h want 0/0", ifc.Fault, ifc.PCAddress); end
        Rst_n = 1;
    endtask

    task automatic test_random();
        logic [31:0] bt, jt;
        Rst_n = 0; drive(0, 0, 0, 0, 0, 0); step(); Rst_n = 1;
        for (int c = 0; c < 600; c++) begin
            bt = ($urandom_range(0, 99) < 85) ? {20'h0, 10'($urandom), 2'b00} : $urandom;
            jt = ($urandom_range(0, 99) < 85) ? {20'h0, 10'($urandom), 2'b00} : $urandom;
            drive($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 8, bt, $urandom_range(0, 99) < 5, jt);
            Rst_n = !($urandom_range(0, 99) < 1 || (m_mode == 2 && $urandom_range(0, 99) < 20));
            step();
            n_checks++;
            if (ifc.PCAddress !== m_pc || ifc.IFID_Instruction !== m_instr || ifc.IFID_Valid !== m_valid ||
                ifc.Fault !== m_fault || ifc.FetchCount !== m_count || (m_valid && ifc.IFID_PCPlus4 !== m_p4)) begin
                n_fail++;
                $display("FAIL random[%0d] pc %h/%h instr %h/%h p4 %h/%h valid %b/%b fault %b/%b cnt %0d/%0d (got/want)",
                         c, ifc.PCAddress, m_pc, ifc.IFID_Instruction, m_instr, ifc.IFID_PCPlus4, m_p4,
                         ifc.IFID_Valid, m_valid, ifc.Fault, m_fault, ifc.FetchCount, m_count);
            end
        end
    endtask

    task automatic test_top_of_memory();
        int n;
        drive(0, 0, 0, 0, 0, 0);
        Rst_n = 0; step(); Rst_n = 1;
        n = 0;
        while (ifc.PCAddress !== 32'hFFC && n < 1100) begin step(); n++; end
        n_checks++; if (ifc.PCAddress !== 32'hFFC) begin n_fail++; $display("FAIL top_reach pc %h want ffc", ifc.PCAddress); end
        n_checks++; if (ifc.IFID_Instruction !== mem[1022] || ifc.IFID_PCPlus4 !== 32'hFFC || ifc.IFID_Valid !== 1'b1 || ifc.FetchCount !== 32'd1023) begin
            n_fail++; $display("FAIL top_capture instr %h p4 %h valid %b cnt %0d want %h/ffc/1/1023", ifc.IFID_Instruction, ifc.IFID_PCPlus4, ifc.IFID_Valid, ifc.FetchCount, mem[1022]); end
        step();
        n_checks++; if (ifc.Fault !== 1'b1 || ifc.PCAddress !== 32'hFFC || ifc.IFID_Valid !== 1'b0 || ifc.IFID_Instruction !== NOP || ifc.FetchCount !== 32'd1023) begin
            n_fail++; $display("FAIL top_fallthrough fault %b pc %h valid %b cnt %0d want 1/ffc/0/1023", ifc.Fault, ifc.PCAddress, ifc.IFID_Valid, ifc.FetchCount); end
    endtask

    initial begin
        Rst_n = 0;
        test_reset();
        test_free_run_stall();
        test_branch();
        test_priority();
        test_fault();
        test_random();
        test_top_of_memory();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
